// File: rtl/renode_pkg.sv
// Shared types for the Renode runtime message path.
// Message fields, action codes and the buffered message record.
package renode_pkg;

  typedef enum logic [7:0] {
    invalidAction = 8'd0,
    tickClock     = 8'd1,
    interrupt     = 8'd2,
    pushData      = 8'd3,
    getData       = 8'd4,
    pushDone      = 8'd5
  } action_t;

  typedef logic [63:0] address_t;
  typedef logic [63:0] data_t;

  localparam int unsigned DropCountWidth = 16;

  typedef struct packed {
    action_t  action;
    address_t addr;
    logic     level;
  } out_msg_t;

endpackage

// File: rtl/renode_msg_fifo.sv
// Width/depth parameterized synchronous FIFO.
// Pointers carry a wrap bit; full is registered, empty from pointers.
module renode_msg_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wr_data,
  input  logic             pop,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic             r_full;
  logic             w_push;
  logic             w_pop;
  logic [PW:0]      w_wptr_nx;
  logic [PW:0]      w_rptr_nx;

  assign empty   = (r_wptr == r_rptr);
  assign full    = r_full;
  assign w_push  = push && !r_full;
  assign w_pop   = pop && !empty;
  assign rd_data = r_mem[r_rptr[PW-1:0]];

  assign w_wptr_nx = r_wptr + {{PW{1'b0}}, w_push};
  assign w_rptr_nx = r_rptr + {{PW{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_full <= 1'b0;
    end else begin
      r_wptr <= w_wptr_nx;
      r_rptr <= w_rptr_nx;
      r_full <= (w_wptr_nx[PW] != w_rptr_nx[PW]) &&
                (w_wptr_nx[PW-1:0] == w_rptr_nx[PW-1:0]);
    end
  end

endmodule

// File: rtl/renode_outputs.sv
// Applies buffered Renode interrupt messages to registered lines.
// Malformed messages are dropped and counted.
module renode_outputs
  import renode_pkg::*;
#(
  parameter int unsigned OutputsCount = 1,
  parameter int unsigned FifoDepth    = 4,
  parameter logic [OutputsCount-1:0] ResetValue = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      msg_valid,
  output logic                      msg_ready,
  input  action_t                   msg_action,
  input  address_t                  msg_addr,
  input  data_t                     msg_data,
  output logic [OutputsCount-1:0]   outputs,
  output logic [OutputsCount-1:0]   outputs_changed,
  output logic [DropCountWidth-1:0] drop_count,
  output logic                      drop_sticky
);

  localparam int unsigned IdxW =
    (OutputsCount > 1) ? $clog2(OutputsCount) : 1;

  logic                      r_en;
  logic [OutputsCount-1:0]   r_out;
  logic [OutputsCount-1:0]   r_chg;
  logic [DropCountWidth-1:0] r_drop;
  logic                      r_sticky;

  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  out_msg_t                  w_wr;
  out_msg_t                  w_head;
  logic                      w_hit;
  logic [IdxW-1:0]           w_idx;
  logic [OutputsCount-1:0]   w_out_nx;
  logic [OutputsCount-1:0]   w_chg_nx;
  logic                      w_drop;

  assign msg_ready = r_en && !w_full;
  assign w_push    = msg_valid && msg_ready;
  assign w_pop     = !w_empty;

  assign w_wr.action = msg_action;
  assign w_wr.addr   = msg_addr;
  assign w_wr.level  = msg_data[0];

  renode_msg_fifo #(
    .Width ($bits(out_msg_t)),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_push),
    .wr_data (w_wr),
    .pop     (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Full-width compare so high address bits never alias onto a line.
  assign w_hit = (w_head.action == interrupt) &&
                 (w_head.addr < address_t'(OutputsCount));
  assign w_idx = w_head.addr[IdxW-1:0];

  always_comb begin
    w_out_nx = r_out;
    w_chg_nx = '0;
    w_drop   = 1'b0;
    if (w_pop) begin
      if (w_hit) begin
        w_out_nx[w_idx] = w_head.level;
        w_chg_nx[w_idx] = r_out[w_idx] ^ w_head.level;
      end else begin
        w_drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en     <= 1'b0;
      r_out    <= ResetValue;
      r_chg    <= '0;
      r_drop   <= '0;
      r_sticky <= 1'b0;
    end else begin
      r_en  <= 1'b1;
      r_out <= w_out_nx;
      r_chg <= w_chg_nx;
      if (w_drop) begin
        r_sticky <= 1'b1;
        if (r_drop != '1) r_drop <= r_drop + 1'b1;
      end
    end
  end

  assign outputs         = r_out;
  assign outputs_changed = r_chg;
  assign drop_count      = r_drop;
  assign drop_sticky     = r_sticky;

endmodule

// File: doc/renode_outputs.md
# renode_outputs

Receive-side counterpart to the input-sampling block. It accepts interrupt messages that the Renode runtime emits toward the HDL side: `address` selects an output line and `data[0]` gives the new level. Messages are buffered in a small FIFO, applied one per cycle to registered output lines, and malformed messages are dropped and counted. It sits between the runtime-connection glue (which performs the DPI receive and presents messages on a valid/ready port) and the simulated design's interrupt/GPIO inputs.

## Interface
Parameters:
- `OutputsCount`, 1: number of driven lines, 1..64.
- `FifoDepth`, 4: message buffer entries; power of two, ≥2.
- `ResetValue`, '0: `[OutputsCount-1:0]` level of `outputs` in reset.

Ports:
- `clk`  in  1  sole clock; all state on posedge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `msg_valid`  in  1  message present.
- `msg_ready`  out  1  FIFO can accept; transfer on `msg_valid && msg_ready`.
- `msg_action`  in  `renode_pkg::action_t`  message action.
- `msg_addr`  in  `renode_pkg::address_t`  line index.
- `msg_data`  in  `renode_pkg::data_t`  bit 0 = level; other bits ignored.
- `outputs`  out  OutputsCount  registered line levels.
- `outputs_changed`  out  OutputsCount  one-cycle pulse per line whose level changed.
- `drop_count`  out  16  saturating count of dropped messages.
- `drop_sticky`  out  1  set on first drop; cleared only by reset.

## Operation
- Ingress: `msg_ready = !full`, registered. No push while full, so there is no push-when-full case.
- FIFO: stores action, addr and data[0]. The push is visible to the apply stage on the next cycle.
- Apply stage: pops the head whenever the FIFO is non-empty, one message per cycle. Handling of the popped message:
  - Valid message (`msg_action == renode_pkg::interrupt` and `msg_addr < OutputsCount`):
    - `outputs[msg_addr] <= data0`.
    - `outputs_changed[msg_addr]` pulses only if the level differs from its old value.
  - Invalid message (any other action, or address out of range):
    - Outputs untouched.
    - `drop_count` increments, saturating at 16'hFFFF.
    - `drop_sticky <= 1`.
- Address compare uses the full `address_t` width; no truncation aliasing. For example, `addr = OutputsCount + 2^k` is out of range.
- Repeated identical messages are legal: no change and no pulse.
- Messages to the same line are applied strictly in arrival order.
- Reset (asynchronous, mid-operation included):
  - FIFO flushed.
  - `outputs = ResetValue`, `outputs_changed = 0`, `drop_count = 0`, `drop_sticky = 0`, `msg_ready = 0`.
  - Any in-flight message is lost.
  - `msg_ready` rises on the first posedge after `rst_n` deasserts.

## Timing
- Accept at edge N → FIFO entry valid after N → `outputs` and `outputs_changed` update at edge N+1. Latency is 2 edges from handshake to visible output with an empty FIFO.
- Throughput is 1 message/cycle sustained. With simultaneous push and pop, FIFO occupancy is unchanged.
- `msg_ready` deasserts the edge the FIFO becomes full. It reasserts the edge after a pop from full.
- `outputs_changed` is high for exactly one cycle per applied change.
- `drop_count` updates in the same cycle the dropped message would have been applied.

## Structure
- `renode_pkg` already supplies `action_t`, `address_t`, `data_t` and the `interrupt` enum value. Add `localparam int unsigned DropCountWidth = 16` there.
- Sub-module `renode_msg_fifo`:
  - Parameterized width/depth synchronous FIFO.
  - Pointers carry a wrap bit (`$clog2(FifoDepth)+1`) for full/empty.
  - Outputs: `full`, `empty`, `rd_data`.
  - Reusable by other runtime-facing blocks.
- Top level: ingress handshake, apply/decode stage, output and counter registers.

## Test plan
- Reset: hold `rst_n=0` with `ResetValue=4'b1010`, `OutputsCount=4` → `outputs=1010`, `msg_ready=0`, `drop_count=0`. Release → `msg_ready=1` after one posedge.
- Single set: interrupt, addr 2, data 1, accepted at edge N → `outputs[2]=1` and `outputs_changed=0100` at edge N+1 only; resending the same message gives no pulse.
- Backpressure: `FifoDepth=4`, push 6 back-to-back messages alternating line 0 levels 1/0 → all 6 accepted without loss, `msg_ready` never low (pop keeps pace). With the apply stage stalled by reset-free burst flow, final `outputs[0]=0`, and six pulses are seen on `outputs_changed[0]`.
- Drops: addr 4 with `OutputsCount=4`, plus one message with a non-interrupt action → `outputs` unchanged, `drop_count=2`, `drop_sticky=1`. Then 70000 bad messages → `drop_count=16'hFFFF`.
- Wide address: addr `64'h1_0000_0001` → dropped, not aliased to line 1.
- Reset mid-burst: assert `rst_n=0` with 3 messages queued → FIFO empty, `outputs=ResetValue`, and no queued message is applied after release.
